// File: rtl/sram_rd_pkg.sv
// Shared types and constants for the SRAM Wishbone stream reader.
package sram_rd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN,
    FIN
  } rd_state_e;

  localparam int LANE_W = 2;
  localparam int WORD_BYTES = 4;
  localparam logic [3:0] SEL_ALL = 4'hF;

endpackage

// File: rtl/sram_wb_stream_reader_if.sv
// Bundles the Wishbone classic read bus and the 8-bit byte stream of the reader.
interface sram_wb_stream_reader_if;

  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_last;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o,
    input  wb_dat_i, wb_ack_i,
    output m_valid, m_data, m_last,
    input  m_ready
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o,
    output wb_dat_i, wb_ack_i,
    input  m_valid, m_data, m_last,
    output m_ready
  );

endinterface

// File: rtl/sram_rd_byte_unpacker.sv
// Holds one fetched SRAM word and presents one byte lane of it, little-endian.
module sram_rd_byte_unpacker
  import sram_rd_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic                      advance,
  input  logic [LANE_W-1:0]         lane_init,
  input  logic [8*WORD_BYTES-1:0]   word_in,
  output logic [7:0]                byte_out
);

  logic [8*WORD_BYTES-1:0] word_q, word_d;
  logic [LANE_W-1:0]       lane_q, lane_d;

  always_comb begin
    word_d = word_q;
    lane_d = lane_q;
    if (load) begin
      word_d = word_in;
      lane_d = lane_init;
    end else if (advance) begin
      lane_d = lane_q + LANE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      lane_q <= '0;
    end else begin
      word_q <= word_d;
      lane_q <= lane_d;
    end
  end

  assign byte_out = word_q[8*lane_q +: 8];

endmodule

// File: rtl/sram_wb_stream_reader.sv
// Reads a byte range from the frame SRAM over Wishbone and streams it out bytewise.
// Optional ack timeout enabled by defining SRAM_RD_TIMEOUT_EN.
module sram_wb_stream_reader
  import sram_rd_pkg::*;
#(
  parameter int ADDR_W = 16
`ifdef SRAM_RD_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 255
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   byte_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  sram_wb_stream_reader_if.master bus
);

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              load, advance, beat;
  logic [7:0]        byte_out;

`ifdef SRAM_RD_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
`endif

  assign beat = (state_q == DRAIN) && bus.m_ready;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    load    = 1'b0;
    advance = 1'b0;
`ifdef SRAM_RD_TIMEOUT_EN
    err_d   = err_q;
    tmo_d   = (state_q == REQ) ? tmo_q + TMO_W'(1) : '0;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cur_d   = start_addr;
          rem_d   = byte_len;
          state_d = (byte_len == '0) ? FIN : REQ;
`ifdef SRAM_RD_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      REQ: begin
        if (bus.wb_ack_i) begin
          load    = 1'b1;
          state_d = DRAIN;
        end
`ifdef SRAM_RD_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = FIN;
        end
`endif
      end
      DRAIN: begin
        if (beat) begin
          advance = 1'b1;
          cur_d   = cur_q + ADDR_W'(1);
          rem_d   = rem_q - (ADDR_W + 1)'(1);
          if (rem_q == (ADDR_W + 1)'(1)) state_d = FIN;
          else if (cur_q[LANE_W-1:0] == '1) state_d = REQ;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q   <= '0;
      rem_q   <= '0;
`ifdef SRAM_RD_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
`ifdef SRAM_RD_TIMEOUT_EN
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`endif
    end
  end

`ifdef SRAM_RD_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  sram_rd_byte_unpacker u_unpacker (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .advance   (advance),
    .lane_init (cur_q[LANE_W-1:0]),
    .word_in   (bus.wb_dat_i),
    .byte_out  (byte_out)
  );

  // Address is forced to zero outside REQ so an idle bus shows no stale address.
  assign bus.wb_cyc_o = (state_q == REQ);
  assign bus.wb_stb_o = (state_q == REQ);
  assign bus.wb_we_o  = 1'b0;
  assign bus.wb_sel_o = SEL_ALL;
  assign bus.wb_adr_o = (state_q == REQ) ?
                        32'({cur_q[ADDR_W-1:LANE_W], {LANE_W{1'b0}}}) : 32'h0;
  assign bus.m_valid  = (state_q == DRAIN);
  assign bus.m_data   = byte_out;
  assign bus.m_last   = (state_q == DRAIN) && (rem_q == (ADDR_W + 1)'(1));
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == FIN);

endmodule

// File: tb/tb_sram_wb_stream_reader.sv
// Directed bench: reader attached to a byte SRAM model holding mem[i]=i[7:0].
module tb_sram_wb_stream_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] start_addr = '0;
  logic [16:0] byte_len = '0;
  logic        busy, done, err;

  logic        ack_en = 1'b1;
  logic        toggle_en = 1'b0;
  logic        hold_low = 1'b0;
  logic        tgl = 1'b0;
  logic        ack_r = 1'b0;
  logic [31:0] dat_r = '0;

  int total = 0;
  int bad = 0;

  logic [8:0]  rx_q[$];
  logic [31:0] adr_q[$];
  int          cyc_rises = 0;
  int          done_cnt = 0;
  int          stall_bad = 0;
  logic        cyc_prev = 1'b0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;
  logic        prev_last = 1'b0;

  sram_wb_stream_reader_if bus ();

  sram_wb_stream_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .byte_len   (byte_len),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Registered responder: one ack per request, data built from mem[i]=i[7:0].
  always @(posedge clk) begin
    if (rst) begin
      ack_r <= 1'b0;
    end else begin
      ack_r <= bus.wb_cyc_o && bus.wb_stb_o && !ack_r && ack_en;
      dat_r <= {8'(bus.wb_adr_o + 32'd3), 8'(bus.wb_adr_o + 32'd2),
                8'(bus.wb_adr_o + 32'd1), 8'(bus.wb_adr_o)};
    end
  end

  always begin
    @(posedge clk);
    #1 tgl = ~tgl;
  end

  assign bus.wb_ack_i = ack_r;
  assign bus.wb_dat_i = dat_r;
  assign bus.m_ready  = hold_low ? 1'b0 : (toggle_en ? tgl : 1'b1);

  always @(negedge clk) begin
    if (bus.m_valid && bus.m_ready) rx_q.push_back({bus.m_last, bus.m_data});
    if (bus.wb_cyc_o && !cyc_prev) cyc_rises++;
    cyc_prev = bus.wb_cyc_o;
    if (bus.wb_cyc_o && bus.wb_ack_i) adr_q.push_back(bus.wb_adr_o);
    if (done) done_cnt++;
    if (prev_stall && !(bus.m_valid && bus.m_data == prev_data && bus.m_last == prev_last))
      stall_bad++;
    prev_stall = bus.m_valid && !bus.m_ready && !rst;
    prev_data  = bus.m_data;
    prev_last  = bus.m_last;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clearLogs();
    rx_q.delete();
    adr_q.delete();
    cyc_rises = 0;
    done_cnt  = 0;
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [16:0] l);
    start      = 1'b1;
    start_addr = a;
    byte_len   = l;
    tick();
    start      = 1'b0;
    start_addr = 16'hDEAD;
    byte_len   = 17'h0_0001;
  endtask

  task automatic runTransfer(input logic [15:0] a, input logic [16:0] l, input string tag,
                             output int n);
    clearLogs();
    applyStimulus(a, l);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    checkOutput({tag, "_first"}, 32'((l == 0) ? done : bus.wb_cyc_o), 32'd1);
    n = 0;
    while (!done && n < 2000) begin
      tick();
      n++;
    end
    if (!done) checkOutput({tag, "_wait_done"}, 32'd0, 32'd1);
    tick();
    checkOutput({tag, "_busyoff"}, 32'(busy), 32'd0);
    tick();
    checkOutput({tag, "_donecnt"}, 32'(done_cnt), 32'd1);
  endtask

  task automatic checkBytes(input logic [15:0] a, input int l, input string tag);
    checkOutput({tag, "_nbytes"}, 32'(rx_q.size()), 32'(l));
    for (int i = 0; i < l; i++) begin
      if (i < rx_q.size())
        checkOutput($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]),
                    32'({(i == l - 1), 8'(a + 16'(i))}));
    end
  endtask

  task automatic checkAdr(input int idx, input logic [31:0] exp, input string tag);
    checkOutput($sformatf("%s_adr%0d", tag, idx),
                (idx < adr_q.size()) ? adr_q[idx] : 32'hFFFF_FFFF, exp);
  endtask

  initial begin
    int n;
    repeat (3) tick();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_cyc", 32'(bus.wb_cyc_o), 32'd0);
    checkOutput("rst_valid", 32'(bus.m_valid), 32'd0);
    rst = 1'b0;
    tick();

    runTransfer(16'h0010, 17'd8, "t1", n);
    checkBytes(16'h0010, 8, "t1");
    checkOutput("t1_nreads", 32'(adr_q.size()), 32'd2);
    checkAdr(0, 32'h10, "t1");
    checkAdr(1, 32'h14, "t1");

    runTransfer(16'h0003, 17'd3, "t2", n);
    checkBytes(16'h0003, 3, "t2");
    checkOutput("t2_nreads", 32'(adr_q.size()), 32'd2);
    checkAdr(0, 32'h0, "t2");
    checkAdr(1, 32'h4, "t2");

    toggle_en = 1'b1;
    stall_bad = 0;
    runTransfer(16'h0020, 17'd6, "t3", n);
    toggle_en = 1'b0;
    checkBytes(16'h0020, 6, "t3");
    checkOutput("t3_buscycles", 32'(cyc_rises), 32'd2);
    checkOutput("t3_stall_stable", 32'(stall_bad), 32'd0);

    runTransfer(16'h0100, 17'd0, "t4", n);
    checkOutput("t4_latency", 32'(n), 32'd0);
    checkOutput("t4_buscycles", 32'(cyc_rises), 32'd0);
    checkOutput("t4_nbytes", 32'(rx_q.size()), 32'd0);

    runTransfer(16'hFFFE, 17'd4, "t5", n);
    checkBytes(16'hFFFE, 4, "t5");
    checkAdr(0, 32'hFFFC, "t5");
    checkAdr(1, 32'h0000, "t5");

    clearLogs();
    hold_low = 1'b1;
    applyStimulus(16'h0040, 17'd8);
    n = 0;
    while (!bus.m_valid && n < 50) begin
      tick();
      n++;
    end
    checkOutput("t6_in_drain", 32'(bus.m_valid), 32'd1);
    rst = 1'b1;
    tick();
    checkOutput("t6_busy", 32'(busy), 32'd0);
    checkOutput("t6_done", 32'(done), 32'd0);
    checkOutput("t6_err", 32'(err), 32'd0);
    checkOutput("t6_cyc", 32'(bus.wb_cyc_o), 32'd0);
    checkOutput("t6_stb", 32'(bus.wb_stb_o), 32'd0);
    checkOutput("t6_adr", bus.wb_adr_o, 32'd0);
    checkOutput("t6_valid", 32'(bus.m_valid), 32'd0);
    checkOutput("t6_data", 32'(bus.m_data), 32'd0);
    checkOutput("t6_last", 32'(bus.m_last), 32'd0);
    rst = 1'b0;
    hold_low = 1'b0;
    tick();

`ifdef SRAM_RD_TIMEOUT_EN
    clearLogs();
    ack_en = 1'b0;
    applyStimulus(16'h0080, 17'd4);
    n = 0;
    while (!done && n < 1000) begin
      tick();
      n++;
    end
    checkOutput("t7_tmo_cycles", 32'(n), 32'd255);
    checkOutput("t7_err", 32'(err), 32'd1);
    checkOutput("t7_cyc", 32'(bus.wb_cyc_o), 32'd0);
    tick();
    checkOutput("t7_nbytes", 32'(rx_q.size()), 32'd0);
    ack_en = 1'b1;
    runTransfer(16'h0000, 17'd1, "t8", n);
    checkOutput("t8_err_clear", 32'(err), 32'd0);
`else
    checkOutput("t7_err_tied", 32'(err), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
